// File: rtl/wb_stage.sv
// Writeback stage: ALU results written straight back, loads issued to data memory then extracted/extended.
// Optional misaligned-load trap enabled by defining WB_MISALIGN_TRAP_EN.
module wb_stage #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic          ex_reg_wr,
    input  logic [4:0]    ex_rd_addr,
    input  logic          ex_is_load,
    input  logic [2:0]    ex_funct3,
    input  logic [31:0]   ex_result,
    output logic          mem_req,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          wb_we,
    output logic [4:0]    wb_rd,
    output logic [31:0]   wb_data,
    output logic          load_busy,
    output logic [4:0]    load_rd,
    output logic          load_misalign
);

    // state  | meaning
    // S_IDLE | accepting instructions; ALU results written next cycle
    // S_REQ  | read request presented, waiting for mem_req_ready
    // S_WAIT | request accepted, waiting for mem_rvalid
    // S_WB   | extracted load data on the write port for one cycle
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

    state_t      state, state_nxt;
    logic [4:0]  rd_q;
    logic        reg_wr_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        accept;
    logic        misalign;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign ex_ready  = (state == S_IDLE) && !reset;
    assign accept    = ex_valid && ex_ready;
    assign mem_req   = (state == S_REQ);
    assign load_busy = (state != S_IDLE);
    assign load_rd   = load_busy ? rd_q : 5'd0;

`ifdef WB_MISALIGN_TRAP_EN
    logic misalign_q;
    // funct3[1] set covers LW and the codes treated as LW; 01 in the low bits is LH/LHU
    assign misalign = ex_is_load &&
                      ((ex_funct3[1] && ex_result[1:0] != 2'b00) ||
                       (ex_funct3[1:0] == 2'b01 && ex_result[0]));
    assign load_misalign = misalign_q;

    always_ff @(posedge clk) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= accept && misalign;
    end
`else
    assign misalign      = 1'b0;
    assign load_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && ex_is_load && !misalign) state_nxt = S_REQ;
            S_REQ:   if (mem_req_ready) state_nxt = S_WAIT;
            S_WAIT:  if (mem_rvalid) state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_we    <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'd0;
            mem_addr <= '0;
            rd_q     <= 5'd0;
            reg_wr_q <= 1'b0;
            funct3_q <= 3'd0;
            offset_q <= 2'd0;
        end else begin
            wb_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && !ex_is_load) begin
                        wb_we   <= ex_reg_wr && (ex_rd_addr != 5'd0);
                        wb_rd   <= ex_rd_addr;
                        wb_data <= ex_result;
                    end else if (accept && !misalign) begin
                        rd_q     <= ex_rd_addr;
                        reg_wr_q <= ex_reg_wr;
                        funct3_q <= ex_funct3;
                        offset_q <= ex_result[1:0];
                        mem_addr <= {ex_result[AW-1:2], 2'b00};
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        wb_we   <= reg_wr_q && (rd_q != 5'd0);
                        wb_rd   <= rd_q;
                        wb_data <= extract(mem_rdata, funct3_q, offset_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized ALU/load traffic against a reference model.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_ready, ex_reg_wr, ex_is_load;
    logic [4:0]  ex_rd_addr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_result;
    logic        mem_req, mem_req_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        load_busy, load_misalign;
    logic [4:0]  load_rd;

    int checks = 0;
    int errors = 0;

    wb_stage #(.AW(32)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_reg_wr(ex_reg_wr),
        .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load), .ex_funct3(ex_funct3),
        .ex_result(ex_result),
        .mem_req(mem_req), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .load_busy(load_busy), .load_rd(load_rd), .load_misalign(load_misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected writeback data computed from the load rules by shifting and masking.
    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [31:0] addr);
        int unsigned off;
        longint v;
        off = addr % 4;
        if (f3 == 3'b000 || f3 == 3'b100) begin
            v = longint'((w >> (8 * off)) & 32'hFF);
            if (f3 == 3'b000 && v >= 128) v = v - 256;
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
            v = longint'((w >> (16 * (off / 2))) & 32'hFFFF);
            if (f3 == 3'b001 && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(w);
        end
        return v[31:0];
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return (addr % 2) != 0;
        return (addr % 4) != 0;
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; ex_reg_wr = 0; ex_rd_addr = 0; ex_is_load = 0; ex_funct3 = 0;
        ex_result = 0; mem_req_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic alu_issue(input logic rw, input logic [4:0] rd, input logic [31:0] res);
        ex_valid = 1; ex_is_load = 0; ex_reg_wr = rw; ex_rd_addr = rd; ex_result = res;
        ex_funct3 = 3'($urandom_range(0, 7));
    endtask

    // Full load transaction: r cycles of stall on mem_req_ready, rvalid d cycles after acceptance.
    task automatic do_load(input logic [4:0] rd, input logic rw, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input int r, input int d);
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic        exp_we;
        bit          trap;
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_data = exp_load(rdata, f3, addr);
        exp_we   = rw && (rd != 5'd0);
        trap     = 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
        trap = is_misaligned(f3, addr);
`endif
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL ld_ready_T: got %b exp 1", ex_ready); end
        ex_valid = 1; ex_is_load = 1; ex_reg_wr = rw; ex_rd_addr = rd; ex_funct3 = f3; ex_result = addr;
        mem_rvalid = 1'($urandom_range(0, 1));
        tick();
        ex_valid = 0; ex_is_load = 0; ex_result = $urandom;
        if (trap) begin
            checks++; if (load_misalign !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %b exp 1", load_misalign); end
            checks++; if (mem_req !== 1'b0 || load_busy !== 1'b0 || ex_ready !== 1'b1) begin errors++;
                $display("FAIL misalign_state: req %b busy %b ready %b exp 0 0 1", mem_req, load_busy, ex_ready); end
            tick();
            checks++; if (load_misalign !== 1'b0 || wb_we !== 1'b0) begin errors++;
                $display("FAIL misalign_after: misalign %b we %b exp 0 0", load_misalign, wb_we); end
            return;
        end
        checks++; if (load_misalign !== 1'b0) begin errors++; $display("FAIL misalign_quiet: got %b exp 0", load_misalign); end
        for (int i = 0; i <= r; i++) begin
            mem_req_ready = (i == r);
            mem_rvalid = 1'($urandom_range(0, 1));
            checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin errors++;
                $display("FAIL ld_req: req %b addr %h exp 1 %h", mem_req, mem_addr, exp_addr); end
            checks++; if (ex_ready !== 1'b0 || load_busy !== 1'b1 || load_rd !== rd || wb_we !== 1'b0) begin errors++;
                $display("FAIL ld_req_status: ready %b busy %b rd %0d we %b exp 0 1 %0d 0", ex_ready, load_busy, load_rd, rd, wb_we); end
            tick();
        end
        mem_req_ready = 0;
        mem_rvalid = 0;
        for (int i = 1; i < d; i++) begin
            mem_req_ready = 1'($urandom_range(0, 1));
            checks++; if (mem_req !== 1'b0 || ex_ready !== 1'b0 || load_rd !== rd || mem_addr !== exp_addr) begin errors++;
                $display("FAIL ld_wait: req %b ready %b rd %0d addr %h exp 0 0 %0d %h", mem_req, ex_ready, load_rd, mem_addr, rd, exp_addr); end
            tick();
        end
        mem_rvalid = 1; mem_rdata = rdata; mem_req_ready = 0;
        tick();
        mem_rvalid = 0; mem_rdata = $urandom;
        checks++; if (wb_we !== exp_we || wb_rd !== rd || wb_data !== exp_data) begin errors++;
            $display("FAIL ld_wb: we %b rd %0d data %h exp %b %0d %h", wb_we, wb_rd, wb_data, exp_we, rd, exp_data); end
        checks++; if (ex_ready !== 1'b0 || load_busy !== 1'b1) begin errors++;
            $display("FAIL ld_wb_status: ready %b busy %b exp 0 1", ex_ready, load_busy); end
        tick();
        checks++; if (wb_we !== 1'b0 || ex_ready !== 1'b1 || load_busy !== 1'b0 || load_rd !== 5'd0) begin errors++;
            $display("FAIL ld_done: we %b ready %b busy %b rd %0d exp 0 1 0 0", wb_we, ex_ready, load_busy, load_rd); end
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        #1;
        checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_pre: got %b exp 0", ex_ready); end
        tick(); tick();
        checks++; if ({ex_ready, mem_req, wb_we, wb_rd, wb_data, mem_addr, load_busy, load_rd, load_misalign} !== '0) begin errors++;
            $display("FAIL reset_outputs: ready %b req %b we %b rd %0d data %h addr %h busy %b lrd %0d mis %b exp all 0",
                     ex_ready, mem_req, wb_we, wb_rd, wb_data, mem_addr, load_busy, load_rd, load_misalign); end
        reset = 0;
        #1;
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_post: got %b exp 1", ex_ready); end
        tick();
    endtask

    task automatic test_alu();
        alu_issue(1, 5'd5, 32'h0000_1234);
        tick();
        ex_valid = 0;
        checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h0000_1234) begin errors++;
            $display("FAIL alu_write: we %b rd %0d data %h exp 1 5 00001234", wb_we, wb_rd, wb_data); end
        tick();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL alu_pulse: we %b exp 0", wb_we); end
    endtask

    task automatic test_x0_back_to_back();
        alu_issue(1, 5'd0, 32'hDEAD_BEEF);
        tick();
        checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'hDEAD_BEEF || ex_ready !== 1'b1) begin errors++;
            $display("FAIL x0_suppress: we %b rd %0d data %h ready %b exp 0 0 deadbeef 1", wb_we, wb_rd, wb_data, ex_ready); end
        alu_issue(1, 5'd31, 32'hCAFE_0001);
        tick();
        ex_valid = 0;
        checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd31 || wb_data !== 32'hCAFE_0001) begin errors++;
            $display("FAIL b2b_write: we %b rd %0d data %h exp 1 31 cafe0001", wb_we, wb_rd, wb_data); end
        tick();
    endtask

    task automatic test_lb_lbu();
        do_load(5'd7, 1, 3'b000, 32'h0000_0103, 32'h80FF_0000, 0, 1);
        do_load(5'd8, 1, 3'b100, 32'h0000_0103, 32'h80FF_0000, 1, 1);
    endtask

    task automatic test_lh_stall();
        do_load(5'd12, 1, 3'b001, 32'h0000_0202, 32'h8001_ABCD, 3, 2);
    endtask

    task automatic test_misaligned_lw();
        do_load(5'd9, 1, 3'b010, 32'h0000_1002, 32'h1357_9BDF, 0, 1);
    endtask

    task automatic test_reset_midop();
        ex_valid = 1; ex_is_load = 1; ex_reg_wr = 1; ex_rd_addr = 5'd3; ex_funct3 = 3'b010; ex_result = 32'h0000_4444;
        tick();
        ex_valid = 0; ex_is_load = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        checks++; if (load_busy !== 1'b1 || mem_req !== 1'b0) begin errors++;
            $display("FAIL rst_mid_wait: busy %b req %b exp 1 0", load_busy, mem_req); end
        reset = 1;
        #1;
        checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b exp 0", ex_ready); end
        tick();
        checks++; if ({ex_ready, mem_req, wb_we, wb_rd, wb_data, mem_addr, load_busy, load_rd} !== '0) begin errors++;
            $display("FAIL rst_mid_outputs: ready %b req %b we %b rd %0d data %h addr %h busy %b lrd %0d exp all 0",
                     ex_ready, mem_req, wb_we, wb_rd, wb_data, mem_addr, load_busy, load_rd); end
        reset = 0; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 0;
        checks++; if (wb_we !== 1'b0 || ex_ready !== 1'b1 || load_busy !== 1'b0 || wb_data !== 32'd0) begin errors++;
            $display("FAIL rst_mid_ignore: we %b ready %b busy %b data %h exp 0 1 0 0", wb_we, ex_ready, load_busy, wb_data); end
        tick();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rst_mid_nowrite: we %b exp 0", wb_we); end
    endtask

    task automatic test_random_alu();
        logic        pv, prw;
        logic [4:0]  prd;
        logic [31:0] pres;
        pv = 0; prw = 0; prd = 0; pres = 0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) alu_issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            else ex_valid = 0;
            if (pv) begin
                checks++; if (wb_we !== (prw && prd != 5'd0) || wb_rd !== prd || wb_data !== pres) begin errors++;
                    $display("FAIL rand_alu: we %b rd %0d data %h exp %b %0d %h", wb_we, wb_rd, wb_data, prw && prd != 5'd0, prd, pres); end
            end else begin
                checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rand_alu_idle: we %b exp 0", wb_we); end
            end
            pv = ex_valid; prw = ex_reg_wr; prd = ex_rd_addr; pres = ex_result;
            tick();
        end
        ex_valid = 0;
        tick();
    endtask

    task automatic test_random_loads();
        for (int i = 0; i < 40; i++) begin
            do_load(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
            if ($urandom_range(0, 1) != 0) begin
                alu_issue(1, 5'($urandom_range(1, 31)), $urandom);
                tick();
                ex_valid = 0;
                checks++; if (wb_we !== 1'b1 || wb_rd !== ex_rd_addr || wb_data !== ex_result) begin errors++;
                    $display("FAIL rand_mix_alu: we %b rd %0d data %h exp 1 %0d %h", wb_we, wb_rd, wb_data, ex_rd_addr, ex_result); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_x0_back_to_back();
        test_lb_lbu();
        test_lh_stall();
        test_misaligned_lw();
        test_reset_midop();
        test_random_alu();
        test_random_loads();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
